// File: rtl/adder_check_pkg.sv
// Shared FSM state type, 32-bit counter width and saturating increment for the adder result checker.
package adder_check_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/adder_cmp_stage.sv
// Stage-1 capture of one ref/DUV vector and its mismatch decision; 1 edge from load to vld.
// No backpressure: load captures unconditionally, vld drops on the next edge without load.
module adder_cmp_stage
  import adder_check_pkg::*;
#(
  parameter int N    = 64,
  parameter int TYPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] s_ref,
  input  logic [N-1:0] s_duv,
  input  logic         cout_ref,
  input  logic         cout_duv,
  input  logic         prop_ref,
  input  logic         gen_ref,
  input  logic         prop_duv,
  input  logic         gen_duv,
  output logic         vld,
  output logic         mismatch,
  output logic [N-1:0] cap_a,
  output logic [N-1:0] cap_b,
  output logic         cap_cin
);

  localparam bit CHK_PG = (TYPE == 1);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s_ref;
    logic [N-1:0] s_duv;
    logic         cin;
    logic         cout_ref;
    logic         cout_duv;
    logic         prop_ref;
    logic         gen_ref;
    logic         prop_duv;
    logic         gen_duv;
  } vec_t;

  vec_t vec_d, vec_q;
  logic vld_d, vld_q;

  // Payload holds when not loading so idle cycles do not toggle the wide registers.
  always_comb begin
    vec_d = vec_q;
    vld_d = load;
    if (load) begin
      vec_d.a        = a;
      vec_d.b        = b;
      vec_d.s_ref    = s_ref;
      vec_d.s_duv    = s_duv;
      vec_d.cin      = cin;
      vec_d.cout_ref = cout_ref;
      vec_d.cout_duv = cout_duv;
      vec_d.prop_ref = prop_ref;
      vec_d.gen_ref  = gen_ref;
      vec_d.prop_duv = prop_duv;
      vec_d.gen_duv  = gen_duv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vec_q <= vec_d;
      vld_q <= vld_d;
    end
  end

  assign vld      = vld_q;
  assign mismatch = vld_q &&
                    ((vec_q.s_ref != vec_q.s_duv) ||
                     (vec_q.cout_ref != vec_q.cout_duv) ||
                     (CHK_PG && ((vec_q.prop_ref != vec_q.prop_duv) ||
                                 (vec_q.gen_ref != vec_q.gen_duv))));
  assign cap_a    = vec_q.a;
  assign cap_b    = vec_q.b;
  assign cap_cin  = vec_q.cin;

endmodule

// File: rtl/adder_result_checker.sv
// Compares reference vs DUV adder results over NUM_VECTORS vectors; counters lag acceptance by 2 edges.
// No backpressure (in_valid only honoured in RUN); STOP_ON_FIRST_ERR_EN ends the run at the first mismatch.
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int          N           = 64,
  parameter int          TYPE        = 1,
  parameter int unsigned NUM_VECTORS = 30000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             cin,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     s_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  input  logic             prop_ref,
  input  logic             gen_ref,
  input  logic             prop_duv,
  input  logic             gen_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_index,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b,
  output logic             first_err_cin
);

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] acc_cnt_d, acc_cnt_q;
  logic [CNT_W-1:0] vec_count_d, vec_count_q;
  logic [CNT_W-1:0] err_count_d, err_count_q;
  logic             fe_valid_d, fe_valid_q;
  logic [CNT_W-1:0] fe_index_d, fe_index_q;
  logic [N-1:0]     fe_a_d, fe_a_q;
  logic [N-1:0]     fe_b_d, fe_b_q;
  logic             fe_cin_d, fe_cin_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;

  logic             accept;
  logic             cmp_vld;
  logic             cmp_mis;
  logic [N-1:0]     cap_a;
  logic [N-1:0]     cap_b;
  logic             cap_cin;

`ifdef STOP_ON_FIRST_ERR_EN
  logic stop_hit;
  // The mismatch is visible combinationally from stage 1, so the same edge can refuse a new vector.
  assign stop_hit = cmp_mis && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign accept   = (state_q == ST_RUN) && in_valid && !stop_hit;
`else
  assign accept   = (state_q == ST_RUN) && in_valid;
`endif

  adder_cmp_stage #(
    .N    (N),
    .TYPE (TYPE)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .s_ref    (s_ref),
    .s_duv    (s_duv),
    .cout_ref (cout_ref),
    .cout_duv (cout_duv),
    .prop_ref (prop_ref),
    .gen_ref  (gen_ref),
    .prop_duv (prop_duv),
    .gen_duv  (gen_duv),
    .vld      (cmp_vld),
    .mismatch (cmp_mis),
    .cap_a    (cap_a),
    .cap_b    (cap_b),
    .cap_cin  (cap_cin)
  );

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    fe_valid_d  = fe_valid_q;
    fe_index_d  = fe_index_q;
    fe_a_d      = fe_a_q;
    fe_b_d      = fe_b_q;
    fe_cin_d    = fe_cin_q;

    // Stage 2: the index recorded is the post-increment count, i.e. 1-based vector number.
    if (cmp_vld) begin
      vec_count_d = vec_count_q + CNT_ONE;
      if (cmp_mis) begin
        err_count_d = sat_inc(err_count_q);
        if (!fe_valid_q) begin
          fe_valid_d = 1'b1;
          fe_index_d = vec_count_q + CNT_ONE;
          fe_a_d     = cap_a;
          fe_b_d     = cap_b;
          fe_cin_d   = cap_cin;
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          acc_cnt_d   = '0;
          vec_count_d = '0;
          err_count_d = '0;
          fe_valid_d  = 1'b0;
          fe_index_d  = '0;
          fe_a_d      = '0;
          fe_b_d      = '0;
          fe_cin_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_ONE;
          if ((acc_cnt_q + CNT_ONE) == LAST_VEC) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

`ifdef STOP_ON_FIRST_ERR_EN
    if (stop_hit) begin
      state_d = ST_DONE;
    end
`endif

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_cnt_q   <= '0;
      vec_count_q <= '0;
      err_count_q <= '0;
      fe_valid_q  <= 1'b0;
      fe_index_q  <= '0;
      fe_a_q      <= '0;
      fe_b_q      <= '0;
      fe_cin_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      fe_valid_q  <= fe_valid_d;
      fe_index_q  <= fe_index_d;
      fe_a_q      <= fe_a_d;
      fe_b_q      <= fe_b_d;
      fe_cin_q    <= fe_cin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_count       = vec_count_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_index = fe_index_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;
  assign first_err_cin   = fe_cin_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: TYPE=1 and TYPE=0 four-vector instances plus a ten-vector instance.
// The ten-vector expectations follow STOP_ON_FIRST_ERR_EN when that macro is defined.
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0;
  logic        start10 = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic [63:0] a = '0, b = '0, s_ref = '0, s_duv = '0;
  logic        cout_ref = 1'b0, cout_duv = 1'b0;
  logic        prop_ref = 1'b0, gen_ref = 1'b0, prop_duv = 1'b0, gen_duv = 1'b0;

  logic        o1_busy, o1_done, o1_pass, o1_fev, o1_fcin;
  logic [31:0] o1_vec, o1_err, o1_fidx;
  logic [63:0] o1_fa, o1_fb;
  logic        o0_busy, o0_done, o0_pass, o0_fev, o0_fcin;
  logic [31:0] o0_vec, o0_err, o0_fidx;
  logic [63:0] o0_fa, o0_fb;
  logic        o10_busy, o10_done, o10_pass, o10_fev, o10_fcin;
  logic [31:0] o10_vec, o10_err, o10_fidx;
  logic [63:0] o10_fa, o10_fb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.N(64), .TYPE(1), .NUM_VECTORS(4)) dut1 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(o1_busy), .done(o1_done), .pass(o1_pass), .vec_count(o1_vec), .err_count(o1_err),
    .first_err_valid(o1_fev), .first_err_index(o1_fidx), .first_err_a(o1_fa),
    .first_err_b(o1_fb), .first_err_cin(o1_fcin));

  adder_result_checker #(.N(64), .TYPE(0), .NUM_VECTORS(4)) dut0 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(o0_busy), .done(o0_done), .pass(o0_pass), .vec_count(o0_vec), .err_count(o0_err),
    .first_err_valid(o0_fev), .first_err_index(o0_fidx), .first_err_a(o0_fa),
    .first_err_b(o0_fb), .first_err_cin(o0_fcin));

  adder_result_checker #(.N(64), .TYPE(1), .NUM_VECTORS(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref), .cout_duv(cout_duv),
    .prop_ref(prop_ref), .gen_ref(gen_ref), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(o10_busy), .done(o10_done), .pass(o10_pass), .vec_count(o10_vec), .err_count(o10_err),
    .first_err_valid(o10_fev), .first_err_index(o10_fidx), .first_err_a(o10_fa),
    .first_err_b(o10_fb), .first_err_cin(o10_fcin));

  // Vector k (1-based); vector 3 is the all-ones + 1 carry-ripple case.
  task automatic drive_vec(input int k, input logic v, input logic se, input logic ce, input logic pe);
    logic [64:0] sum;
    logic [64:0] ab;
    logic [31:0] kk;
    kk = k;
    if (k == 3) begin
      a   = 64'hFFFF_FFFF_FFFF_FFFF;
      b   = 64'd1;
      cin = 1'b0;
    end else begin
      a   = 64'h0123_4567_89AB_CDEF ^ {32'h0, kk};
      b   = {32'h0000_1000, kk};
      cin = kk[0];
    end
    ab       = {1'b0, a} + {1'b0, b};
    sum      = ab + {64'd0, cin};
    s_ref    = sum[63:0];
    cout_ref = sum[64];
    prop_ref = &(a ^ b);
    gen_ref  = ab[64];
    s_duv    = s_ref ^ {63'd0, se};
    cout_duv = cout_ref ^ ce;
    prop_duv = prop_ref ^ pe;
    gen_duv  = gen_ref;
    in_valid = v;
  endtask

  // Starts the 4-vector instances, plays an in_valid pattern (MSB first) and waits for done.
  task automatic run4(input logic [6:0] pat, input int plen, input logic [3:0] smask,
                      input logic [3:0] cmask, input logic [3:0] pmask);
    int k;
    int lat;
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    n_cmp++;
    if (o1_vec !== 32'd0 || o1_err !== 32'd0 || o1_fev !== 1'b0 || o1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_clear: vec=%0d err=%0d fev=%b busy=%b, want 0 0 0 1", o1_vec, o1_err, o1_fev, o1_busy);
    end
    k = 0;
    for (int i = 0; i < plen; i++) begin
      if (pat[plen-1-i]) begin
        k++;
        drive_vec(k, 1'b1, smask[k-1], cmask[k-1], pmask[k-1]);
      end else begin
        drive_vec(0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (o1_done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL done_latency: cycles after last accept edge=%0d, want 1", lat);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o1_busy !== 1'b0 || o1_done !== 1'b0 || o1_pass !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b done=%b pass=%b, want 000", o1_busy, o1_done, o1_pass);
    end
    n_cmp++;
    if (o1_vec !== 32'd0 || o1_err !== 32'd0 || o1_fidx !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counts: vec=%0d err=%0d fidx=%0d, want 0", o1_vec, o1_err, o1_fidx);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o1_fev !== 1'b0 || o1_fa !== 64'd0 || o10_busy !== 1'b0 || o10_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: fev=%b fa=%h b10=%b d10=%b, want 0", o1_fev, o1_fa, o10_busy, o10_done);
    end
  endtask

  task automatic test_all_match();
    run4(7'b0001111, 4, 4'b0000, 4'b0000, 4'b0000);
    n_cmp++;
    if (o1_vec !== 32'd4 || o1_err !== 32'd0) begin
      n_err++;
      $display("FAIL match_counts: vec=%0d err=%0d, want 4 0", o1_vec, o1_err);
    end
    n_cmp++;
    if (o1_pass !== 1'b1 || o1_busy !== 1'b0 || o1_fev !== 1'b0) begin
      n_err++;
      $display("FAIL match_pass: pass=%b busy=%b fev=%b, want 1 0 0", o1_pass, o1_busy, o1_fev);
    end
  endtask

  task automatic test_first_err();
    run4(7'b0001111, 4, 4'b0100, 4'b0000, 4'b0000);
    n_cmp++;
    if (o1_err !== 32'd1 || o1_fidx !== 32'd3 || o1_pass !== 1'b0 || o1_fev !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_count: err=%0d fidx=%0d pass=%b fev=%b, want 1 3 0 1", o1_err, o1_fidx, o1_pass, o1_fev);
    end
    n_cmp++;
    if (o1_fa !== 64'hFFFF_FFFF_FFFF_FFFF || o1_fb !== 64'd1 || o1_fcin !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_data: a=%h b=%h cin=%b, want all-ones 1 0", o1_fa, o1_fb, o1_fcin);
    end
    run4(7'b0001111, 4, 4'b0000, 4'b1001, 4'b0000);
    n_cmp++;
    if (o1_err !== 32'd2 || o1_fidx !== 32'd1 || o1_vec !== 32'd4) begin
      n_err++;
      $display("FAIL ferr_keep: err=%0d fidx=%0d vec=%0d, want 2 1 4", o1_err, o1_fidx, o1_vec);
    end
    n_cmp++;
    if (o1_fa !== 64'h0123_4567_89AB_CDEE || o1_fb !== 64'h0000_1000_0000_0001 || o1_fcin !== 1'b1) begin
      n_err++;
      $display("FAIL ferr_keep_data: a=%h b=%h cin=%b", o1_fa, o1_fb, o1_fcin);
    end
  endtask

  task automatic test_type();
    run4(7'b0001111, 4, 4'b0000, 4'b0000, 4'b0010);
    n_cmp++;
    if (o0_err !== 32'd0 || o0_pass !== 1'b1) begin
      n_err++;
      $display("FAIL type0_prop: err=%0d pass=%b, want 0 1", o0_err, o0_pass);
    end
    n_cmp++;
    if (o1_err !== 32'd1 || o1_pass !== 1'b0 || o1_fidx !== 32'd2) begin
      n_err++;
      $display("FAIL type1_prop: err=%0d pass=%b fidx=%0d, want 1 0 2", o1_err, o1_pass, o1_fidx);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    drive_vec(1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive_vec(2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (o1_vec !== 32'd1 || o1_busy !== 1'b1) begin
      n_err++;
      $display("FAIL pipe_latency: vec=%0d busy=%b after 2 accepts, want 1 1", o1_vec, o1_busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o1_busy !== 1'b0 || o1_vec !== 32'd0 || o1_done !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_rst: busy=%b vec=%0d done=%b, want 0 0 0", o1_busy, o1_vec, o1_done);
    end
    @(negedge clk) rst = 1'b0;
    run4(7'b0001111, 4, 4'b0000, 4'b0000, 4'b0000);
    n_cmp++;
    if (o1_vec !== 32'd4 || o1_pass !== 1'b1) begin
      n_err++;
      $display("FAIL after_rst_run: vec=%0d pass=%b, want 4 1", o1_vec, o1_pass);
    end
  endtask

  task automatic test_gaps();
    run4(7'b1001101, 7, 4'b0000, 4'b0000, 4'b0000);
    n_cmp++;
    if (o1_vec !== 32'd4 || o1_pass !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_count: vec=%0d pass=%b, want 4 1", o1_vec, o1_pass);
    end
    drive_vec(5, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (o1_vec !== 32'd4 || o1_err !== 32'd0 || o1_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignore: vec=%0d err=%0d done=%b, want 4 0 1", o1_vec, o1_err, o1_done);
    end
  endtask

  task automatic test_stop();
    int lat;
    logic [31:0] exp_vec;
`ifdef STOP_ON_FIRST_ERR_EN
    exp_vec = 32'd2;
`else
    exp_vec = 32'd10;
`endif
    @(negedge clk) start10 = 1'b1;
    @(negedge clk) start10 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive_vec(k, 1'b1, (k == 2), 1'b0, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    lat = 0;
    while (o10_done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (o10_done !== 1'b1) begin
      n_err++;
      $display("FAIL stop_done: done=%b, want 1", o10_done);
    end
    n_cmp++;
    if (o10_vec !== exp_vec || o10_err !== 32'd1 || o10_fidx !== 32'd2 || o10_pass !== 1'b0) begin
      n_err++;
      $display("FAIL stop_counts: vec=%0d err=%0d fidx=%0d pass=%b, want %0d 1 2 0",
               o10_vec, o10_err, o10_fidx, o10_pass, exp_vec);
    end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_first_err();
    test_type();
    test_reset_midrun();
    test_gaps();
    test_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
